// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load and serial handshake bundle for piso_serializer
// slave  : serializer side (takes load_valid/load_data/ser_ready, drives the rest)
// master : upstream/downstream side (drives load_valid/load_data/ser_ready)
interface piso_serializer_if #(parameter int WIDTH = 8);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             ser_ready;
  logic             busy;
  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );
  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: WIDTH-bit word in over valid/ready, shifted out LSB first
// Ports: clk, rst_n (async, active-low), bus (piso_serializer_if.slave):
//   load_valid/load_data/load_ready upstream word handshake,
//   ser_out/ser_valid/ser_last/ser_ready serial bit handshake, busy frame in progress.
// Option: define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  piso_serializer_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t          state;
  logic [N-1:0]    sh;
  logic [CW-1:0]   cnt;
  logic            last;
  // Outputs depend only on state, counter and shift register, never on ready/valid inputs.
  assign last           = (state == SHIFT) && (cnt == CW'(N - 1));
  assign bus.load_ready = (state == IDLE);
  assign bus.ser_valid  = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.ser_out    = sh[0];
  assign bus.ser_last   = last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.load_valid) begin
`ifdef PISO_PARITY_EN
        sh    <= {^bus.load_data, bus.load_data};
`else
        sh    <= bus.load_data;
`endif
        cnt   <= '0;
        state <= SHIFT;
      end
    end else if (bus.ser_ready) begin
      // Zeros shift in, so ser_out settles to 0 once the frame drains.
      sh    <= sh >> 1;
      cnt   <= last ? '0 : cnt + 1'b1;
      state <= last ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif
  logic clk = 0;
  logic rst_n = 1;
  int n_cmp = 0;
  int n_err = 0;
  piso_serializer_if #(.WIDTH(8)) bus ();
  piso_serializer #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  // {load_ready, ser_valid, ser_out, ser_last, busy}
  function automatic logic [4:0] obs();
    return {bus.load_ready, bus.ser_valid, bus.ser_out, bus.ser_last, bus.busy};
  endfunction

  task automatic test_reset();
    #13 rst_n = 0;
    #1 n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL reset: got %b want 10000", obs());
    end
    @(negedge clk) rst_n = 1;
    @(negedge clk) n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_release: got %b want 10000", obs());
    end
  endtask

  task automatic test_single(input logic [7:0] d, input logic [8:0] e);
    bus.load_valid = 1;
    bus.load_data  = d;
    bus.ser_ready  = 1;
    @(negedge clk) bus.load_valid = 0;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs() !== {3'b010 | {2'b00, e[i]}, i == N - 1, 1'b1}) begin
        n_err++;
        $display("FAIL single_%h bit%0d: got %b want %b", d, i, obs(), {2'b01, e[i], i == N - 1, 1'b1});
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL single_%h idle: got %b want 10000", d, obs());
    end
  endtask

  task automatic test_stall();
    logic [8:0] e = 9'h03C;
    bus.load_valid = 1;
    bus.load_data  = 8'h3C;
    bus.ser_ready  = 1;
    @(negedge clk) bus.load_valid = 0;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs() !== {2'b01, e[i], i == N - 1, 1'b1}) begin
        n_err++;
        $display("FAIL stall bit%0d: got %b want %b", i, obs(), {2'b01, e[i], i == N - 1, 1'b1});
      end
      if (i == 2) begin
        bus.ser_ready = 0;
        repeat (3) begin
          @(negedge clk) n_cmp++;
          if (obs() !== 5'b01101) begin
            n_err++;
            $display("FAIL stall_hold: got %b want 01101", obs());
          end
        end
        bus.ser_ready = 1;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL stall idle: got %b want 10000", obs());
    end
  endtask

  task automatic test_busy_ignore();
    logic [8:0] e = 9'h0FF;
    bus.load_valid = 1;
    bus.load_data  = 8'hFF;
    bus.ser_ready  = 1;
    @(negedge clk) bus.load_valid = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 3) begin
        bus.load_valid = 1;
        bus.load_data  = 8'h00;
      end
      n_cmp++;
      if (obs() !== {2'b01, e[i], i == N - 1, 1'b1}) begin
        n_err++;
        $display("FAIL busy_ignore bit%0d: got %b want %b", i, obs(), {2'b01, e[i], i == N - 1, 1'b1});
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL busy_ignore idle: got %b want 10000", obs());
    end
    @(negedge clk) bus.load_valid = 0;
    n_cmp++;
    if (obs() !== 5'b01001) begin
      n_err++;
      $display("FAIL busy_ignore second: got %b want 01001", obs());
    end
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [8:0] e = 9'h0A5;
    bus.load_valid = 1;
    bus.load_data  = 8'hA5;
    bus.ser_ready  = 1;
    @(negedge clk) bus.load_valid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs() !== {2'b01, e[i], 2'b01}) begin
        n_err++;
        $display("FAIL reset_mid bit%0d: got %b want %b", i, obs(), {2'b01, e[i], 2'b01});
      end
      @(negedge clk);
    end
    #2 rst_n = 0;
    #1 n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_mid abort: got %b want 10000", obs());
    end
    @(negedge clk) rst_n = 1;
    repeat (3) begin
      @(negedge clk) n_cmp++;
      if (obs() !== 5'b10000) begin
        n_err++;
        $display("FAIL reset_mid after: got %b want 10000", obs());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e1 = 9'h107;
    logic [8:0] e2 = 9'h003;
    bus.load_valid = 1;
    bus.load_data  = 8'h07;
    bus.ser_ready  = 1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs() !== {2'b01, e1[i], i == N - 1, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_first bit%0d: got %b want %b", i, obs(), {2'b01, e1[i], i == N - 1, 1'b1});
      end
      if (i == N - 1) bus.load_data = 8'h03;
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL b2b gap: got %b want 10000", obs());
    end
    @(negedge clk) bus.load_valid = 0;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (obs() !== {2'b01, e2[i], i == N - 1, 1'b1}) begin
        n_err++;
        $display("FAIL b2b_second bit%0d: got %b want %b", i, obs(), {2'b01, e2[i], i == N - 1, 1'b1});
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== 5'b10000) begin
      n_err++;
      $display("FAIL b2b idle: got %b want 10000", obs());
    end
  endtask

  initial begin
    bus.load_valid = 0;
    bus.load_data  = '0;
    bus.ser_ready  = 1;
    test_reset();
    test_single(8'hA5, 9'h0A5);
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_single(8'h07, 9'h107);
    test_single(8'h03, 9'h003);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage feeding the 2:1 select datapath. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per accepted cycle, LSB first, with its own valid/ready handshake. Downstream it drives the mux data input; upstream it consumes words from the register/ALU stage.

## Interface

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- load_valid  input  1  upstream word available.
- load_data  input  WIDTH  upstream word.
- load_ready  output  1  high when a word can be accepted.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_last  output  1  current bit is the final bit of the frame.
- ser_ready  input  1  downstream accepts the current bit this cycle.
- busy  output  1  a frame is in progress.

## Operation

- Two states: IDLE and SHIFT.
- IDLE:
  - load_ready=1, ser_valid=0, busy=0.
  - On load_valid && load_ready, capture load_data into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT:
  - load_ready=0, ser_valid=1, busy=1.
  - ser_out = shift_reg[0].
  - A bit transfers on ser_valid && ser_ready. Each transfer shifts the register right by one and increments the counter.
  - With ser_ready=0, ser_out, ser_last and the counter hold unchanged.
- Frame length N = WIDTH bits, or WIDTH+1 with parity enabled (see Configuration).
- ser_last=1 only while counter == N-1 in SHIFT.
- When the last bit transfers, go to IDLE.
- Bit counter width is $clog2(WIDTH+2). The counter never exceeds N-1.
- load_valid asserted while in SHIFT is ignored. The upstream must hold the word until load_ready.

## Timing

- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift register=0, counter=0.
  - load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- Reset mid-frame aborts the frame immediately. No partial bits are emitted after rst_n deasserts.
- Load latency: a word accepted at edge k presents bit 0 on ser_out after edge k (cycle k+1).
- Full-rate throughput with ser_ready held at 1: one bit per cycle, N cycles in SHIFT, then one IDLE cycle. That gives one frame per N+1 cycles.
- Back-to-back frames: load_ready returns to 1 in the cycle after the last bit transfers. No word is accepted in the same cycle as a last-bit transfer.
- All outputs are registered or decoded from state/counter only. There is no combinational path from ser_ready or load_valid to any output.

## Configuration

- Macro: PISO_PARITY_EN.
- Defined:
  - Each frame carries one extra bit after the WIDTH data bits: even parity, the XOR of all data bits captured at load.
  - N = WIDTH+1. ser_last is asserted on the parity bit.
- Undefined:
  - No parity logic is built. N = WIDTH and ser_last is asserted on data bit WIDTH-1.

## Test plan

- Reset: drive rst_n=0 mid-cycle -> outputs immediately show load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- Single frame, WIDTH=8, load 8'hA5, ser_ready=1 -> ser_out sequence is 1,0,1,0,0,1,0,1 on 8 consecutive cycles. ser_last is high on the 8th cycle only. load_ready=1 on the 9th cycle.
- Stall: load 8'h3C, drop ser_ready for 3 cycles after bit 2 -> ser_out holds 1 (bit 2) for those cycles. The full sequence is still 0,0,1,1,1,1,0,0 with no bit lost or duplicated.
- Busy ignore: load 8'hFF, then pulse load_valid with 8'h00 during SHIFT -> all 8 bits are 1 and 8'h00 is not captured until load_ready=1.
- Reset mid-frame: load 8'hA5, assert rst_n=0 after bit 3 -> ser_valid=0 at once. After release, ser_valid stays 0 until a new load.
- PISO_PARITY_EN defined, load 8'h07 -> 9 bits emitted: 1,1,1,0,0,0,0,0 then parity 1, with ser_last on the 9th bit. Loading 8'h03 gives parity 0.
